// File: rtl/frac_block_tx_if.sv
// Bus bundle for frac_block_tx: row write port, start/busy control, the
// streamed filter/reference rows and the search-result return path.
//   master : the feeder block (consumes writes/start/mv_in, drives stream/result)
//   slave  : host / search-unit side
interface frac_block_tx_if;
    logic        wr_en;
    logic        wr_sel;
    logic [2:0]  wr_row;
    logic [63:0] wr_data;
    logic        start;
    logic        busy;
    logic [63:0] filter_pix;
    logic [63:0] ref_pix;
    logic        input_ready;
    logic [2:0]  mvx_in;
    logic [2:0]  mvy_in;
    logic        mv_valid;
    logic [2:0]  mvx;
    logic [2:0]  mvy;

    modport master (
        input  wr_en, wr_sel, wr_row, wr_data, start, mvx_in, mvy_in,
        output busy, filter_pix, ref_pix, input_ready, mv_valid, mvx, mvy
    );

    modport slave (
        output wr_en, wr_sel, wr_row, wr_data, start, mvx_in, mvy_in,
        input  busy, filter_pix, ref_pix, input_ready, mv_valid, mvx, mvy
    );
endinterface

// File: rtl/frac_block_tx.sv
// Transmit-side feeder for the fractional-pel search unit.
// Holds an 8x8 filter block and an 8x8 reference block (one 64-bit row per
// write), streams both one row per cycle on start, then captures the returned
// motion vector after RESULT_WAIT idle cycles and pulses mv_valid.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous reset, active low
//   abort  : (only with FRAC_TX_ABORT_EN defined) cancel a transfer in SEND/WAIT
//   bus    : frac_block_tx_if.master (write port, start/busy, stream, result)
// Optional feature macro: FRAC_TX_ABORT_EN
module frac_block_tx #(
    parameter int unsigned NROWS       = 8,
    parameter int unsigned RESULT_WAIT = 1
) (
    input  logic clk,
    input  logic reset,
`ifdef FRAC_TX_ABORT_EN
    input  logic abort,
`endif
    frac_block_tx_if.master bus
);

    localparam int unsigned WaitW    = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;
    localparam logic [2:0]  LastRow  = 3'(NROWS - 1);
    localparam logic [WaitW-1:0] LastWait = WaitW'(RESULT_WAIT - 1);

    typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_t;

    state_t            state_q, state_d;
    logic [2:0]        row_q, row_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic [63:0]       fpix_q, fpix_d;
    logic [63:0]       rpix_q, rpix_d;
    logic [2:0]        mvx_q, mvx_d;
    logic [2:0]        mvy_q, mvy_d;

    logic [63:0] filt_mem [8];
    logic [63:0] ref_mem  [8];

    logic        abort_req;
    logic        wr_ok;
    logic [63:0] fwd_f0;
    logic [63:0] fwd_r0;

`ifdef FRAC_TX_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Writes only land while idle, so the buffers are frozen for a transfer.
    assign wr_ok = bus.wr_en && (state_q == StIdle) && ({1'b0, bus.wr_row} < 4'(NROWS));

    // Row 0 leaves on the start edge itself, so a same-cycle write to row 0
    // has to be forwarded; later rows read the already-updated buffer.
    assign fwd_f0 = (wr_ok && !bus.wr_sel && bus.wr_row == 3'd0) ? bus.wr_data : filt_mem[0];
    assign fwd_r0 = (wr_ok &&  bus.wr_sel && bus.wr_row == 3'd0) ? bus.wr_data : ref_mem[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                filt_mem[i] <= '0;
                ref_mem[i]  <= '0;
            end
        end else if (wr_ok) begin
            if (bus.wr_sel) ref_mem[bus.wr_row]  <= bus.wr_data;
            else            filt_mem[bus.wr_row] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            row_q   <= '0;
            wait_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            fpix_q  <= '0;
            rpix_q  <= '0;
            mvx_q   <= '0;
            mvy_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            fpix_q  <= fpix_d;
            rpix_q  <= rpix_d;
            mvx_q   <= mvx_d;
            mvy_q   <= mvy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        wait_d  = wait_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        valid_d = 1'b0;
        fpix_d  = '0;
        rpix_d  = '0;
        mvx_d   = mvx_q;
        mvy_d   = mvy_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StSend;
                    row_d   = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b1;
                    fpix_d  = fwd_f0;
                    rpix_d  = fwd_r0;
                end
            end
            StSend: begin
                if (abort_req) begin
                    state_d = StIdle;
                    row_d   = '0;
                    busy_d  = 1'b0;
                end else if (row_q == LastRow) begin
                    state_d = StWait;
                    wait_d  = '0;
                end else begin
                    row_d   = row_q + 3'd1;
                    ready_d = 1'b1;
                    fpix_d  = filt_mem[row_q + 3'd1];
                    rpix_d  = ref_mem[row_q + 3'd1];
                end
            end
            StWait: begin
                if (abort_req) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else if (wait_q == LastWait) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                    mvx_d   = bus.mvx_in;
                    mvy_d   = bus.mvy_in;
                end else begin
                    wait_d  = wait_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.input_ready = ready_q;
    assign bus.mv_valid    = valid_q;
    assign bus.filter_pix  = fpix_q;
    assign bus.ref_pix     = rpix_q;
    assign bus.mvx         = mvx_q;
    assign bus.mvy         = mvy_q;

endmodule

// File: doc/frac_block_tx.md
Name: frac_block_tx

Overview:
- Transmit-side feeder for the fractional-pel search unit.
- Holds one 8x8 filter block and one 8x8 reference block, loaded row-wise by the host or motion-estimation controller.
- On start, streams both blocks one 64-bit row per cycle with input_ready held high for NROWS consecutive cycles.
- Captures the returned mvx/mvy after a fixed result latency and presents them with a one-cycle valid pulse.

Parameters:
- NROWS, 8: rows per block streamed per transfer; row index width is 3 bits.
- RESULT_WAIT, 1: idle cycles after the last row before the search result is sampled.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-low (0 = reset asserted).
- wr_en  in  1  write one row into the block buffer.
- wr_sel  in  1  0 = filter block, 1 = reference block.
- wr_row  in  3  row index 0..NROWS-1.
- wr_data  in  64  8 pixels x 8 bits; pixel 0 in bits [7:0].
- start  in  1  request a transfer (single-cycle pulse or level).
- busy  out  1  transfer in progress.
- filter_pix  out  64  streamed filter row.
- ref_pix  out  64  streamed reference row.
- input_ready  out  1  row valid on filter_pix/ref_pix.
- mvx_in  in  3  search result x, from the search unit.
- mvy_in  in  3  search result y, from the search unit.
- mv_valid  out  1  one-cycle pulse; mvx/mvy updated.
- mvx  out  3  latched result x, two's complement.
- mvy  out  3  latched result y, two's complement.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous):
  - state returns to IDLE.
  - busy, input_ready, mv_valid = 0; filter_pix, ref_pix, mvx, mvy = 0.
  - Both 8x64 buffers and the row/wait counters are cleared to 0.
  - Reset mid-transfer aborts immediately; no mv_valid is produced.
- States: IDLE, SEND, WAIT, DONE.
- IDLE:
  - wr_en writes wr_data into the buffer selected by wr_sel at row wr_row on the clock edge.
  - A start sampled high moves to SEND.
  - A write in the same cycle as start is included in the transfer.
- SEND:
  - Row counter runs 0..NROWS-1.
  - Each cycle drives filter_pix/ref_pix = buffer[row] with input_ready=1.
  - The first row appears the cycle after start is sampled; exactly NROWS consecutive input_ready cycles, no gaps.
  - After row NROWS-1 the block goes to WAIT with input_ready=0 and the pixel outputs forced to 0.
- WAIT:
  - Runs for RESULT_WAIT cycles.
  - On the edge ending the last WAIT cycle, latch mvx<=mvx_in and mvy<=mvy_in, then go to DONE.
- DONE: mv_valid=1 for one cycle, then IDLE.
- mvx/mvy hold their value until the next latch.
- busy=1 from the cycle after start is sampled through the DONE cycle inclusive.
- Total: start edge to mv_valid = 1 + NROWS + RESULT_WAIT cycles (10 with defaults).
- While busy:
  - wr_en is ignored; buffer contents stay stable for the whole transfer.
  - start is ignored.
  - A start held high through DONE is re-sampled in the following IDLE cycle.
- Out-of-range wr_row (only possible when NROWS<8) is ignored.
- Only the active-state row is ever driven; row counter wrap is not observable.

Optional Feature:
- Macro FRAC_TX_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 sampled in SEND or WAIT returns to IDLE on the next edge: input_ready, busy = 0, no mv_valid, mvx/mvy unchanged.
  - abort in IDLE or DONE has no effect.
  - abort has priority over start in the same cycle.
- Not defined: the abort port is absent and every accepted start runs to DONE.

Test Plan:
- Load filter rows r with 64'h0101010101010101*r and ref rows with 64'h0202020202020202*r, pulse start -> input_ready high for exactly 8 cycles starting 1 cycle later; row k carries those values in order.
- Tie mvx_in=3'b111, mvy_in=3'b000 -> mv_valid pulses exactly 10 cycles after the start edge; mvx=-1 and mvy=0 stay held afterwards.
- Write row 3 with wr_en in the same cycle as start -> streamed row 3 shows the new data. Write with wr_en during SEND -> ignored; a following transfer still shows the old row.
- Hold start high continuously -> back-to-back transfers; each has 8 input_ready cycles, separated by 2 idle cycles plus 1 IDLE cycle, with one mv_valid per transfer.
- Assert reset=0 at SEND row 4 -> all outputs 0 immediately, no mv_valid; after release, a new start streams zeroed buffers.
- With FRAC_TX_ABORT_EN, assert abort at row 2 -> input_ready low next cycle, busy low, no mv_valid, mvx unchanged.
